// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg
// Shared types and constants for the idli core. This slice carries the pieces
// used by the UART receiver: the SQI nibble type, the UART byte width and the
// receive FSM state encoding.
// -----------------------------------------------------------------------------
package idli_pkg;

  // One nibble of data as moved around the SQI-facing datapath.
  typedef logic [3:0] sqi_data_t;

  // Width of one UART character (8N1 framing).
  localparam int UART_DATA_W = 8;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } urx_state_t;

endpackage

// File: rtl/idli_urx_fifo_m.sv
// -----------------------------------------------------------------------------
// idli_urx_fifo_m
// Small byte FIFO between the UART receive FSM and the nibble output stage.
// A push into a full FIFO is accepted when the head is popped in the same
// cycle, so a byte arriving just as the consumer frees a slot is not lost.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset (empties the FIFO)
//   push       write push_data at the tail
//   pop        remove the head entry (ignored when empty)
//   push_data  byte to write
//   head_data  byte at the head of the FIFO
//   full       all DEPTH entries occupied
//   empty      no entries occupied
// -----------------------------------------------------------------------------
module idli_urx_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop frees the head slot this cycle, which is what lets a push proceed
  // while full. DEPTH is a power of two, so the pointers wrap naturally.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idli_uart_rx_m.sv
// -----------------------------------------------------------------------------
// idli_uart_rx_m
// UART receiver for the idli core. Synchronises the serial pin, recovers 8N1
// frames, buffers completed bytes in idli_urx_fifo_m and streams them out as
// nibbles (low nibble first) under a valid/accept handshake. Runs on the
// free-running core clock so nothing is lost while the core is stalled.
//
// Ports:
//   i_urx_gck       core clock
//   i_urx_rst       asynchronous active-high reset
//   i_urx_rx        serial input pin, asynchronous, idle high
//   o_urx_data      current nibble of the head byte
//   o_urx_data_vld  o_urx_data valid (FIFO non-empty)
//   i_urx_data_acp  consumer takes the nibble this cycle
//   o_urx_ovf       one-cycle pulse: completed byte dropped, FIFO full
//   o_urx_err       one-cycle pulse on a framing error
//                   (present only when IDLI_UART_RX_ERR_EN is defined)
//
// Build option IDLI_UART_RX_ERR_EN: when defined, the stop bit is checked and
// a frame with a low stop bit is discarded and flagged on o_urx_err. When not
// defined, every completed frame is pushed.
// -----------------------------------------------------------------------------
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      i_urx_gck,
  input  logic      i_urx_rst,
  input  logic      i_urx_rx,
  output sqi_data_t o_urx_data,
  output logic      o_urx_data_vld,
  input  logic      i_urx_data_acp,
  output logic      o_urx_ovf
`ifdef IDLI_UART_RX_ERR_EN
  ,
  output logic      o_urx_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  logic                   rx_meta;
  logic                   rx_s;
  urx_state_t             state;
  logic [TW-1:0]          timer;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   hi;
  logic                   stop_done;
  logic                   stop_ok;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [UART_DATA_W-1:0] head;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_urx_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    stop_done = (state == STOP) && (timer == BIT_LAST);
`ifdef IDLI_UART_RX_ERR_EN
    stop_ok   = rx_s;
`else
    stop_ok   = 1'b1;
`endif
    push      = stop_done && stop_ok;
    pop       = o_urx_data_vld && i_urx_data_acp && hi;
  end

  // Receive FSM. The idle cycle that first sees the low level counts as
  // cycle 0 of the start bit, so START begins with the timer at 1 and the
  // start-bit check lands mid-bit. Every later sample is then one full bit
  // period after the previous one, and STOP returns to IDLE at the middle of
  // the stop bit so a following frame can start immediately.
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      o_urx_ovf <= 1'b0;
`ifdef IDLI_UART_RX_ERR_EN
      o_urx_err <= 1'b0;
`endif
    end else begin
      o_urx_ovf <= push && full && !pop;
`ifdef IDLI_UART_RX_ERR_EN
      o_urx_err <= stop_done && !rx_s;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= TW'(1);
          end else begin
            timer <= '0;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Nibble select: the first accept moves to the high nibble, the second
  // accept pops the byte and returns to the low nibble.
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      hi <= 1'b0;
    end else if (o_urx_data_vld && i_urx_data_acp) begin
      hi <= !hi;
    end
  end

  idli_urx_fifo_m #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (i_urx_gck),
    .rst       (i_urx_rst),
    .push      (push),
    .pop       (pop),
    .push_data (shreg),
    .head_data (head),
    .full      (full),
    .empty     (empty)
  );

  assign o_urx_data_vld = !empty;
  assign o_urx_data     = o_urx_data_vld ? (hi ? head[7:4] : head[3:0]) : '0;

endmodule
